// File: rtl/riscv_enc_pkg.sv
// RV32I subset encoding: op kinds, loader states, opcode/funct fields and the word encoder.
// The field constants are shared with the pipeline's decode path.
package riscv_enc_pkg;

  typedef enum logic [3:0] {
    ADD  = 4'd0,
    SUB  = 4'd1,
    AND  = 4'd2,
    OR   = 4'd3,
    SLT  = 4'd4,
    ADDI = 4'd5,
    LB   = 4'd6,
    SB   = 4'd7,
    BEQ  = 4'd8
  } op_kind_t;

  typedef enum logic [1:0] {StIdle, StLoad, StDrain, StDone} ld_state_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_ADDI    = 3'b000;
  localparam logic [2:0] F3_LB      = 3'b000;
  localparam logic [2:0] F3_SB      = 3'b000;
  localparam logic [2:0] F3_BEQ     = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  // Branch offsets are halfword-aligned, so an odd BEQ offset cannot be encoded.
  function automatic logic op_legal(logic [3:0] kind, logic imm0);
    return (kind <= 4'(BEQ)) && !((kind == 4'(BEQ)) && imm0);
  endfunction

  function automatic logic [31:0] enc_word(op_kind_t kind, logic [4:0] rd, logic [4:0] rs1,
                                           logic [4:0] rs2, logic [12:0] imm);
    logic [31:0] w;
    w = '0;
    case (kind)
      ADD:  w = {F7_BASE, rs2, rs1, F3_ADD_SUB, rd, OPC_OP};
      SUB:  w = {F7_SUB, rs2, rs1, F3_ADD_SUB, rd, OPC_OP};
      AND:  w = {F7_BASE, rs2, rs1, F3_AND, rd, OPC_OP};
      OR:   w = {F7_BASE, rs2, rs1, F3_OR, rd, OPC_OP};
      SLT:  w = {F7_BASE, rs2, rs1, F3_SLT, rd, OPC_OP};
      ADDI: w = {imm[11:0], rs1, F3_ADDI, rd, OPC_OP_IMM};
      LB:   w = {imm[11:0], rs1, F3_LB, rd, OPC_LOAD};
      SB:   w = {imm[11:5], rs2, rs1, F3_SB, imm[4:0], OPC_STORE};
      BEQ:  w = {imm[12], imm[10:5], rs2, rs1, F3_BEQ, imm[4:1], imm[11], OPC_BRANCH};
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with full/empty flags and a head word read straight from the storage registers.
module sync_fifo #(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == (PW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Encodes symbolic RV32I ops into machine words and streams them into instruction memory
// through a small FIFO, tracking address, word count, illegal ops and address wrap.
module instr_encoder_loader
  import riscv_enc_pkg::*;
#(
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [3:0]        op_kind,
  input  logic              op_last,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [12:0]       imm,
  output logic              imem_we,
  input  logic              imem_wready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              done,
  output logic              err_illegal,
  output logic              err_wrap,
  output logic [ADDR_W:0]   word_cnt
);

  ld_state_t         state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   cnt_q;
  logic              err_illegal_q, err_wrap_q;
  logic              fifo_full, fifo_empty;
  logic              accept, legal, push, wr, start_load;
  logic [31:0]       enc;

  assign op_ready = (state_q == StLoad) && !fifo_full;
  assign accept   = op_valid && op_ready;
  assign legal    = op_legal(op_kind, imm[0]);
  assign push     = accept && legal;
  assign enc      = enc_word(op_kind_t'(op_kind), rd, rs1, rs2, imm);
  assign imem_we  = !fifo_empty;
  assign wr       = imem_we && imem_wready;

  assign imem_addr   = addr_q;
  assign word_cnt    = cnt_q;
  assign err_illegal = err_illegal_q;
  assign err_wrap    = err_wrap_q;

  sync_fifo #(
    .W     (32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (enc),
    .pop   (wr),
    .dout  (imem_wdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    done       = 1'b0;
    start_load = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d    = StLoad;
          start_load = 1'b1;
        end
      end
      StLoad: begin
        if (accept && op_last) state_d = StDrain;
      end
      StDrain: begin
        if (fifo_empty) begin
          state_d = StDone;
          done    = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // start_load only fires in IDLE/DONE, where the FIFO is empty, so it never races a write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q        <= ADDR_W'(BASE_ADDR);
      cnt_q         <= '0;
      err_illegal_q <= 1'b0;
      err_wrap_q    <= 1'b0;
    end else if (start_load) begin
      addr_q        <= ADDR_W'(BASE_ADDR);
      cnt_q         <= '0;
      err_illegal_q <= 1'b0;
      err_wrap_q    <= 1'b0;
    end else begin
      if (accept && !legal) err_illegal_q <= 1'b1;
      if (wr) begin
        addr_q <= addr_q + 1'b1;
        cnt_q  <= cnt_q + 1'b1;
        if (&addr_q) err_wrap_q <= 1'b1;
      end
    end
  end

endmodule
